sp_cmd_wb_sequencer: RTL and testbench
======================================

Name: sp_cmd_wb_sequencer

Overview:
- Sequences basic command units inside the stream processor: steers each issued command to one of N_UNITS command units and tracks which units hold an outstanding command.
- Shares the single writeback port among the units using round-robin arbitration. Returns the command's tag on that port and pulses the per-unit ack.
- Sits between the issue stage and the writeback stage, in front of the per-command busy/done units.

Parameters:
- N_UNITS, 4, number of attached command units (2..16).
- ID_W, 6, width of the command tag carried from issue to writeback.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- issue_valid  in  1  issue stage presents a command
- issue_unit  in  $clog2(N_UNITS)  target unit index
- issue_id  in  ID_W  command tag
- issue_ready  out  1  target unit can accept (combinational from state)
- unit_issue  out  N_UNITS  one-hot issue strobe to units
- unit_done  in  N_UNITS  per-unit done level
- unit_ack  out  N_UNITS  one-hot writeback-ack strobe to units
- wb_valid  out  1  writeback request
- wb_unit  out  $clog2(N_UNITS)  unit being written back
- wb_id  out  ID_W  tag of the command being written back
- wb_ack  in  1  writeback consumer accepts
- any_pending  out  1  OR of pending bits
- err_spurious  out  1  sticky: done seen on a non-pending unit

Behaviour:
- Reset (rstn==0 at posedge): all of the following are cleared, regardless of in-flight state. Units are reset by the same rstn.
  - pending[N]=0, tag regs=0, rr_ptr=0, FSM=IDLE.
  - wb_valid=0, wb_unit=0, wb_id=0, err_spurious=0.
  - unit_issue=0, unit_ack=0.
- Issue path:
  - issue_ready = !pending[issue_unit] (registered pending only). issue_unit >= N_UNITS gives issue_ready=0.
  - Accept = issue_valid & issue_ready.
  - On accept, unit_issue[issue_unit]=1 combinationally in that cycle (single-cycle pulse). At the edge, pending[issue_unit] is set and tag[issue_unit] is latched from issue_id.
  - At most one issue per cycle.
- Writeback FSM, states IDLE, WB:
  - IDLE: cand = unit_done & pending. If cand!=0, select the first set bit at or after rr_ptr, with wrap-around modulo N_UNITS. At the edge: wb_unit=sel, wb_id=tag[sel], wb_valid=1, go to WB.
  - WB: wb_valid, wb_unit and wb_id are held stable until wb_ack.
  - On wb_ack in WB:
    - unit_ack[wb_unit]=1 combinationally that cycle.
    - At the edge: pending[wb_unit] cleared, wb_valid=0, rr_ptr=(wb_unit+1) mod N_UNITS, go to IDLE.
  - wb_ack in IDLE is ignored.
- Latency:
  - done asserted at edge t gives wb_valid at t+1 (if FSM is IDLE).
  - Minimum spacing between consecutive writebacks is 2 cycles (one IDLE bubble).
- Simultaneous events:
  - Issue to a unit in the same cycle its ack fires: rejected (issue_ready=0 from registered pending), accepted the next cycle.
  - Issue to unit A while B is in WB: independent, both proceed.
- unit_done[i] & !pending[i] in any cycle sets err_spurious (sticky until reset). That unit is never selected.
- any_pending = |pending (registered).
- Fairness: with all units continuously done, grants rotate 0,1,2,3,0,…

Test Plan:
- Reset then single command: issue_unit=2, issue_id=0x15 → unit_issue=4'b0100 for one cycle. Model unit raises done next cycle → wb_valid one cycle later with wb_unit=2, wb_id=0x15. wb_ack → unit_ack=4'b0100 same cycle, any_pending=0 after.
- Backpressure: issue to unit 1 twice back-to-back → first accepted, issue_ready=0 on the second until the cycle after unit 1's ack, then second accepted with its own tag.
- Round-robin: issue units 0..3 with tags 0x10..0x13, all done together, wb_ack held high → writebacks in order 0,1,2,3 with matching tags, spaced 2 cycles. Repeat with rr_ptr=2 start → order 2,3,0,1.
- Stall: hold wb_ack=0 for 5 cycles while unit 3 is in WB → wb_unit/wb_id unchanged and no unit_ack during the stall. New done on unit 0 is not granted until after unit 3's ack.
- Spurious done: unit_done[1]=1 with pending[1]=0 → err_spurious=1 and stays 1, no wb_valid.
- Reset mid-operation: rstn=0 during WB with 3 units pending → next cycle wb_valid=0, any_pending=0, err_spurious=0, issue_ready=1 for all units.

Source files
------------

// File: rtl/sp_cmd_wb_sequencer.sv
// Command sequencer: steers issued commands to N_UNITS command units, tracks the
// units that hold an outstanding command, and round-robin-shares one writeback port.
module sp_cmd_wb_sequencer #(
    parameter int N_UNITS = 4,
    parameter int ID_W    = 6
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       issue_valid,
    input  logic [$clog2(N_UNITS)-1:0] issue_unit,
    input  logic [ID_W-1:0]            issue_id,
    output logic                       issue_ready,
    output logic [N_UNITS-1:0]         unit_issue,
    input  logic [N_UNITS-1:0]         unit_done,
    output logic [N_UNITS-1:0]         unit_ack,
    output logic                       wb_valid,
    output logic [$clog2(N_UNITS)-1:0] wb_unit,
    output logic [ID_W-1:0]            wb_id,
    input  logic                       wb_ack,
    output logic                       any_pending,
    output logic                       err_spurious
);

    localparam int UW = $clog2(N_UNITS);

    typedef enum logic {
        IDLE = 1'b0,
        WB   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [N_UNITS-1:0]  pending_q, pending_d;
    logic [ID_W-1:0]     tag_q [N_UNITS];
    logic [UW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [UW-1:0]       wb_unit_q, wb_unit_d;
    logic [ID_W-1:0]     wb_id_q, wb_id_d;
    logic                wb_valid_q, wb_valid_d;
    logic                err_q, err_d;

    logic                unit_ok;
    logic                accept;
    logic [N_UNITS-1:0]  cand;
    logic [UW-1:0]       sel;
    logic                sel_found;
    logic [UW-1:0]       rr_after_wb;

    // Readiness looks only at registered pending, so a unit acked this cycle
    // becomes issuable one cycle later.
    assign unit_ok     = (int'(issue_unit) < N_UNITS);
    assign issue_ready = unit_ok && !pending_q[issue_unit];
    assign accept      = issue_valid && issue_ready;
    assign cand        = unit_done & pending_q;
    assign rr_after_wb = (int'(wb_unit_q) == N_UNITS - 1) ? '0 : wb_unit_q + 1'b1;

    // Round-robin pick: first candidate at or after rr_ptr_q, wrapping modulo N_UNITS.
    always_comb begin
        int idx;
        // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
        idx       = 0;
        sel       = '0;
        sel_found = 1'b0;
        for (int k = 0; k < N_UNITS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_UNITS) idx = idx - N_UNITS;
            if (!sel_found && cand[idx]) begin
                sel_found = 1'b1;
                sel       = UW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        rr_ptr_d   = rr_ptr_q;
        wb_unit_d  = wb_unit_q;
        wb_id_d    = wb_id_q;
        wb_valid_d = wb_valid_q;
        unit_issue = '0;
        unit_ack   = '0;

        if (accept) begin
            pending_d[issue_unit]  = 1'b1;
            unit_issue[issue_unit] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    wb_unit_d  = sel;
                    wb_id_d    = tag_q[sel];
                    wb_valid_d = 1'b1;
                    state_d    = WB;
                end
            end
            WB: begin
                if (wb_ack) begin
                    unit_ack[wb_unit_q]  = 1'b1;
                    pending_d[wb_unit_q] = 1'b0;
                    wb_valid_d           = 1'b0;
                    rr_ptr_d             = rr_after_wb;
                    state_d              = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = err_q | (|(unit_done & ~pending_q));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            wb_unit_q  <= '0;
            wb_id_q    <= '0;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            wb_unit_q  <= wb_unit_d;
            wb_id_q    <= wb_id_d;
            wb_valid_q <= wb_valid_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the tag array is small and must read as zero after reset, so it is reset like any other register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < N_UNITS; i++) tag_q[i] <= '0;
        end else if (accept) begin
            tag_q[issue_unit] <= issue_id;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_unit      = wb_unit_q;
    assign wb_id        = wb_id_q;
    assign any_pending  = |pending_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_sp_cmd_wb_sequencer.sv
// Bench for sp_cmd_wb_sequencer: directed scenarios plus random traffic, checked by a
// negedge monitor against a pending-set / tag-scoreboard model of the sequencer.
module tb_sp_cmd_wb_sequencer;

    localparam int N  = 4;
    localparam int UW = 2;
    localparam int IW = 6;

    logic          clk;
    logic          rstn;
    logic          issue_valid;
    logic [UW-1:0] issue_unit;
    logic [IW-1:0] issue_id;
    logic          issue_ready;
    logic [N-1:0]  unit_issue;
    logic [N-1:0]  unit_done;
    logic [N-1:0]  unit_ack;
    logic          wb_valid;
    logic [UW-1:0] wb_unit;
    logic [IW-1:0] wb_id;
    logic          wb_ack;
    logic          any_pending;
    logic          err_spurious;

    sp_cmd_wb_sequencer #(.N_UNITS(N), .ID_W(IW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .issue_valid  (issue_valid),
        .issue_unit   (issue_unit),
        .issue_id     (issue_id),
        .issue_ready  (issue_ready),
        .unit_issue   (unit_issue),
        .unit_done    (unit_done),
        .unit_ack     (unit_ack),
        .wb_valid     (wb_valid),
        .wb_unit      (wb_unit),
        .wb_id        (wb_id),
        .wb_ack       (wb_ack),
        .any_pending  (any_pending),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            unit;
        logic [IW-1:0] id;
    } exp_t;

    exp_t sb[$];          // outstanding commands: expected writeback tag per unit
    int   exp_order[$];   // directed phases: expected grant order
    int   n_checks = 0;
    int   n_errors = 0;
    logic tmo = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] c, input int p);
        for (int k = 0; k < N; k++)
            if (c[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int find_unit(input int u);
        foreach (sb[i]) if (sb[i].unit == u) return i;
        return -1;
    endfunction

    // Reference model: pending set, sticky error, round-robin pointer, grant in flight.
    logic [N-1:0] mp;
    logic         merr;
    int           rr;
    int           held;
    logic         prev_idle;
    logic         prev_ack;
    logic [N-1:0] prev_cand;

    always @(negedge clk) begin : monitor
        logic [N-1:0] cand;
        logic [N-1:0] exp_ack;
        logic [N-1:0] exp_iss;
        logic         exp_valid;
        logic         exp_ready;
        logic         take;
        int           idx;
        if (!rstn) begin
            sb.delete();
            mp        = '0;
            merr      = 1'b0;
            rr        = 0;
            held      = 0;
            prev_idle = 1'b1;
            prev_ack  = 1'b0;
            prev_cand = '0;
        end else begin
            idx = -1;
            if (prev_ack) begin
                exp_valid = 1'b0;
            end else if (prev_idle) begin
                exp_valid = (prev_cand != '0);
                if (exp_valid) held = rr_pick(prev_cand, rr);
            end else begin
                exp_valid = 1'b1;
            end
            check("wb_valid", wb_valid, exp_valid);
            if (exp_valid) begin
                check("wb_unit", wb_unit, held);
                idx = find_unit(held);
                if (idx < 0) check("wb_scoreboard_entry", 0, 1);
                else         check("wb_id", wb_id, sb[idx].id);
            end

            take    = exp_valid && wb_ack;
            exp_ack = '0;
            if (take) exp_ack[held] = 1'b1;
            check("unit_ack", unit_ack, exp_ack);

            exp_ready = !mp[issue_unit];
            check("issue_ready", issue_ready, exp_ready);
            exp_iss = '0;
            if (issue_valid && exp_ready) exp_iss[issue_unit] = 1'b1;
            check("unit_issue", unit_issue, exp_iss);

            check("any_pending", any_pending, |mp);
            check("err_spurious", err_spurious, merr);
            check("issue_timeout", tmo, 0);

            cand = unit_done & mp;
            if (|(unit_done & ~mp)) merr = 1'b1;
            if (take) begin
                if (exp_order.size() > 0) check("rr_order", held, exp_order.pop_front());
                if (idx >= 0) sb.delete(idx);
                mp[held] = 1'b0;
                rr       = (held + 1) % N;
            end
            if (issue_valid && exp_ready) begin
                sb.push_back('{unit: int'(issue_unit), id: issue_id});
                mp[issue_unit] = 1'b1;
            end
            prev_cand = cand;
            prev_idle = !exp_valid;
            prev_ack  = take;
        end
    end

    // Stimulus and a simple unit model: done rises a few cycles after issue
    // (auto mode) and always drops the cycle after the unit is acked.
    logic         auto_done;
    logic [N-1:0] ack_seen;
    logic [N-1:0] iss_seen;
    logic         acc_seen;
    int           dly [N];

    task automatic tick();
        @(negedge clk);
        ack_seen = unit_ack;
        iss_seen = unit_issue;
        acc_seen = issue_valid && issue_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack_seen[i]) unit_done[i] = 1'b0;
            if (auto_done) begin
                if (iss_seen[i]) begin
                    dly[i] = $urandom_range(1, 4);
                end else if (dly[i] > 0) begin
                    dly[i]--;
                    if (dly[i] == 0) unit_done[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic issue(input int u, input logic [IW-1:0] id);
        issue_valid = 1'b1;
        issue_unit  = UW'(u);
        issue_id    = id;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (acc_seen) break;
            if (c == 49) tmo = 1'b1;
        end
        issue_valid = 1'b0;
    endtask

    task automatic do_reset();
        issue_valid = 1'b0;
        wb_ack      = 1'b0;
        rstn        = 1'b0;
        unit_done   = '0;
        for (int i = 0; i < N; i++) dly[i] = 0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        rstn        = 1'b0;
        issue_valid = 1'b0;
        issue_unit  = '0;
        issue_id    = '0;
        unit_done   = '0;
        wb_ack      = 1'b0;
        auto_done   = 1'b0;
        for (int i = 0; i < N; i++) dly[i] = 0;
        do_reset();

        // Single command to unit 2.
        exp_order.push_back(2);
        issue(2, 6'h15);
        unit_done[2] = 1'b1;
        repeat (2) tick();
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        repeat (2) tick();

        // Back-to-back issues to unit 1: second waits for the first's ack.
        auto_done = 1'b1;
        wb_ack    = 1'b1;
        exp_order.push_back(1);
        exp_order.push_back(1);
        issue(1, 6'h2A);
        issue(1, 6'h2B);
        repeat (12) tick();
        auto_done = 1'b0;
        wb_ack    = 1'b0;

        // Round-robin from rr_ptr=0, then from rr_ptr=2.
        do_reset();
        for (int u = 0; u < N; u++) issue(u, IW'(6'h10 + u));
        for (int u = 0; u < N; u++) exp_order.push_back(u);
        unit_done = '1;
        wb_ack    = 1'b1;
        repeat (12) tick();
        wb_ack = 1'b0;
        exp_order.push_back(1);
        issue(1, 6'h21);
        unit_done[1] = 1'b1;
        wb_ack       = 1'b1;
        repeat (4) tick();
        wb_ack = 1'b0;
        for (int u = 0; u < N; u++) issue(u, IW'(6'h10 + u));
        exp_order.push_back(2);
        exp_order.push_back(3);
        exp_order.push_back(0);
        exp_order.push_back(1);
        unit_done = '1;
        wb_ack    = 1'b1;
        repeat (12) tick();
        wb_ack = 1'b0;

        // Stall unit 3 in writeback while unit 0 becomes done.
        exp_order.push_back(3);
        exp_order.push_back(0);
        issue(3, 6'h33);
        unit_done[3] = 1'b1;
        repeat (2) tick();
        issue(0, 6'h30);
        unit_done[0] = 1'b1;
        repeat (5) tick();
        wb_ack = 1'b1;
        repeat (6) tick();
        wb_ack = 1'b0;

        // Spurious done on idle unit 1: sticky error, no writeback.
        unit_done[1] = 1'b1;
        repeat (3) tick();
        unit_done[1] = 1'b0;
        repeat (4) tick();

        // Reset in the middle of a writeback with three units pending.
        issue(0, 6'h01);
        issue(1, 6'h02);
        issue(2, 6'h03);
        unit_done[1] = 1'b1;
        repeat (3) tick();
        exp_order.delete();
        do_reset();
        for (int u = 0; u < N; u++) begin
            issue_unit = UW'(u);
            tick();
        end

        // Random traffic against the model.
        auto_done = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_unit  = UW'($urandom_range(0, N - 1));
            issue_id    = IW'($urandom);
            wb_ack      = ($urandom_range(0, 1) != 0);
            tick();
        end
        issue_valid = 1'b0;
        wb_ack      = 1'b1;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
